// File: rtl/timer_arb_pkg.sv
// Shared types and constants for the timer access arbiter.
// Optional macro TIMER_ARB_LOCK_EN adds requester lock support in the top.
package timer_arb_pkg;

  localparam int unsigned TIM_ADDR_W = 4;
  localparam int unsigned TIM_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  localparam logic [TIM_ADDR_W-1:0] TIM_ADDR_COUNT = 4'h0;
  localparam logic [TIM_ADDR_W-1:0] TIM_ADDR_CTRL  = 4'h1;

  // Command latched at grant time for the duration of one access
  typedef struct packed {
    logic                  wr;
    logic [TIM_ADDR_W-1:0] addr;
  } tim_cmd_t;

  // Increment an index modulo n
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority arbiter: first masked request at or after ptr wins.
module rr_arbiter
  import timer_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]                             req,
  input  logic [NREQ-1:0]                             mask,
  input  logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0]  ptr,
  output logic [NREQ-1:0]                             grant,
  output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0]  idx
);

  localparam int unsigned IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic        found;
  int unsigned pos;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    pos   = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      pos = 32'(ptr) + i;
      if (pos >= NREQ) pos = pos - NREQ;
      if (!found && req[IDXW'(pos)] && mask[IDXW'(pos)]) begin
        found               = 1'b1;
        grant[IDXW'(pos)]   = 1'b1;
        idx                 = IDXW'(pos);
      end
    end
  end

endmodule

// File: rtl/timer_access_arbiter.sv
// Round-robin sharing of one peripheral_timer register port among NREQ requesters.
// Define TIMER_ARB_LOCK_EN to add the req_lock input for atomic access sequences.
module timer_access_arbiter
  import timer_arb_pkg::*;
#(
  parameter int unsigned NREQ          = 4,
  parameter int unsigned STROBE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ-1:0]       req_wr,
  input  logic [4*NREQ-1:0]     req_addr,
`ifdef TIMER_ARB_LOCK_EN
  input  logic [NREQ-1:0]       req_lock,
`endif
  output logic [NREQ-1:0]       req_ready,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [TIM_DATA_W-1:0] rsp_data,
  output logic                  tim_cs,
  output logic                  tim_rd,
  output logic                  tim_wr,
  output logic [TIM_ADDR_W-1:0] tim_addr,
  input  logic [TIM_DATA_W-1:0] tim_rdata
);

  localparam int unsigned IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CNTW = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(STROBE_CYCLES - 1);

  arb_state_e            state_q, state_d;
  logic [CNTW-1:0]       cnt_q, cnt_d;
  logic [IDXW-1:0]       g_q, g_d;
  logic [IDXW-1:0]       ptr_q, ptr_d;
  tim_cmd_t              cmd_q, cmd_d;
  logic [NREQ-1:0]       req_ready_q, req_ready_d;
  logic [NREQ-1:0]       rsp_valid_q, rsp_valid_d;
  logic [TIM_DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic                  tim_cs_q, tim_cs_d;
  logic                  tim_rd_q, tim_rd_d;
  logic                  tim_wr_q, tim_wr_d;
  logic [TIM_ADDR_W-1:0] tim_addr_q, tim_addr_d;
`ifdef TIMER_ARB_LOCK_EN
  logic                  lock_q, lock_d;
`endif

  logic [TIM_ADDR_W-1:0] addr_arr [NREQ];
  logic [NREQ-1:0]       g_onehot;
  logic [NREQ-1:0]       arb_mask;
  logic [NREQ-1:0]       arb_gnt;
  logic [IDXW-1:0]       arb_idx;
  logic [IDXW-1:0]       ptr_inc;
  logic                  arb_any;

  always_comb begin
    for (int i = 0; i < int'(NREQ); i++) addr_arr[i] = req_addr[4*i +: 4];
  end

  always_comb begin
    g_onehot       = '0;
    g_onehot[g_q]  = 1'b1;
  end

  assign ptr_inc = IDXW'(wrap_inc(32'(g_q), NREQ));

  // While locked only the owning requester may win the next grant
`ifdef TIMER_ARB_LOCK_EN
  assign arb_mask = lock_q ? g_onehot : '1;
`else
  assign arb_mask = '1;
`endif

  rr_arbiter #(.NREQ(NREQ)) u_rr_arbiter (
    .req   (req_valid),
    .mask  (arb_mask),
    .ptr   (ptr_q),
    .grant (arb_gnt),
    .idx   (arb_idx)
  );

  assign arb_any = |arb_gnt;

  // Next-state and next-output logic; outputs are registered from the *_d values
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    g_d         = g_q;
    ptr_d       = ptr_q;
    cmd_d       = cmd_q;
    req_ready_d = '0;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    tim_cs_d    = 1'b0;
    tim_rd_d    = 1'b0;
    tim_wr_d    = 1'b0;
    tim_addr_d  = tim_addr_q;
`ifdef TIMER_ARB_LOCK_EN
    lock_d      = lock_q;
`endif

    case (state_q)
      IDLE: begin
`ifdef TIMER_ARB_LOCK_EN
        if (lock_q && !req_valid[g_q]) begin
          lock_d = 1'b0;
          ptr_d  = ptr_inc;
        end
`endif
        if (arb_any) begin
          state_d     = ACCESS;
          cnt_d       = '0;
          g_d         = arb_idx;
          cmd_d.wr    = req_wr[arb_idx];
          cmd_d.addr  = addr_arr[arb_idx];
          req_ready_d = arb_gnt;
          tim_cs_d    = 1'b1;
          tim_rd_d    = ~req_wr[arb_idx];
          tim_wr_d    = req_wr[arb_idx];
          tim_addr_d  = addr_arr[arb_idx];
        end
      end

      ACCESS: begin
        if (cnt_q == CNT_LAST) begin
          state_d     = RESP;
          rsp_valid_d = g_onehot;
          rsp_data_d  = cmd_q.wr ? '0 : tim_rdata;
        end else begin
          cnt_d    = cnt_q + CNTW'(1);
          tim_cs_d = 1'b1;
          tim_rd_d = ~cmd_q.wr;
          tim_wr_d = cmd_q.wr;
        end
      end

      RESP: begin
        state_d = IDLE;
        ptr_d   = ptr_inc;
`ifdef TIMER_ARB_LOCK_EN
        lock_d  = req_lock[g_q];
        if (req_lock[g_q]) ptr_d = g_q;
`endif
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      g_q         <= '0;
      ptr_q       <= '0;
      cmd_q       <= '0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      tim_cs_q    <= 1'b0;
      tim_rd_q    <= 1'b0;
      tim_wr_q    <= 1'b0;
      tim_addr_q  <= '0;
`ifdef TIMER_ARB_LOCK_EN
      lock_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      g_q         <= g_d;
      ptr_q       <= ptr_d;
      cmd_q       <= cmd_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      tim_cs_q    <= tim_cs_d;
      tim_rd_q    <= tim_rd_d;
      tim_wr_q    <= tim_wr_d;
      tim_addr_q  <= tim_addr_d;
`ifdef TIMER_ARB_LOCK_EN
      lock_q      <= lock_d;
`endif
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign tim_cs    = tim_cs_q;
  assign tim_rd    = tim_rd_q;
  assign tim_wr    = tim_wr_q;
  assign tim_addr  = tim_addr_q;

endmodule

// File: tb/tb_timer_access_arbiter.sv
// Self-checking bench for timer_access_arbiter (NREQ=4, STROBE_CYCLES=2).
module tb_timer_access_arbiter;
  import timer_arb_pkg::*;

  localparam int unsigned NREQ = 4;
  localparam int unsigned SC   = 2;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_wr;
  logic [4*NREQ-1:0] req_addr;
`ifdef TIMER_ARB_LOCK_EN
  logic [NREQ-1:0]   req_lock;
`endif
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   rsp_valid;
  logic [15:0]       rsp_data;
  logic              tim_cs, tim_rd, tim_wr;
  logic [3:0]        tim_addr;
  logic [15:0]       tim_rdata;

  logic              use_fixed;
  logic [15:0]       fixed_rdata;

  typedef struct {
    int unsigned idx;
    logic [15:0] data;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          tests_run = 0;
  int          failures  = 0;

  // Timer model: a read of address a returns 16'hC0D0 | a unless a fixed value is forced
  assign tim_rdata = use_fixed ? fixed_rdata : (16'hC0D0 | 16'(tim_addr));

  timer_access_arbiter #(.NREQ(NREQ), .STROBE_CYCLES(SC)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
`ifdef TIMER_ARB_LOCK_EN
    .req_lock  (req_lock),
`endif
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .tim_cs    (tim_cs),
    .tim_rd    (tim_rd),
    .tim_wr    (tim_wr),
    .tim_addr  (tim_addr),
    .tim_rdata (tim_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [NREQ-1:0] oh(input int unsigned i);
    return NREQ'(1) << i;
  endfunction

  // Response monitor: every rsp_valid pulse must match the oldest expected entry
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      tests_run++;
      if (tim_rd && tim_wr) begin
        failures++;
        $display("FAIL strobe_excl: tim_rd=%b tim_wr=%b, required not both high", tim_rd, tim_wr);
      end
      if (rsp_valid !== '0) begin
        tests_run++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL rsp_unexpected: rsp_valid=%b data=%h, required no response", rsp_valid, rsp_data);
        end else begin
          mon_e = sb.pop_front();
          if (rsp_valid !== oh(mon_e.idx) || rsp_data !== mon_e.data) begin
            failures++;
            $display("FAIL rsp_sb: rsp_valid=%b data=%h, required %b data=%h",
                     rsp_valid, rsp_data, oh(mon_e.idx), mon_e.data);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    req_valid = '0;
    req_wr    = '0;
    req_addr  = '0;
`ifdef TIMER_ARB_LOCK_EN
    req_lock  = '0;
`endif
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    clear_inputs();
    use_fixed   = 1'b0;
    fixed_rdata = '0;
    rst = 1'b0;
    repeat (5) tick();
    tests_run++;
    if ({req_ready, rsp_valid, rsp_data, tim_cs, tim_rd, tim_wr, tim_addr} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: ready=%b rsp=%b data=%h cs=%b rd=%b wr=%b addr=%h, required all 0",
               req_ready, rsp_valid, rsp_data, tim_cs, tim_rd, tim_wr, tim_addr);
    end
    rst = 1'b1;
    repeat (2) tick();
    tests_run++;
    if ({req_ready, rsp_valid, tim_cs} !== '0) begin
      failures++;
      $display("FAIL reset_idle: ready=%b rsp=%b cs=%b, required 0 with no requests", req_ready, rsp_valid, tim_cs);
    end
  endtask

  task automatic test_single_write();
    apply_reset();
    req_valid = 4'b0010;
    req_wr    = 4'b0010;
    req_addr  = 16'h0010;
    sb.push_back('{idx: 1, data: 16'h0000});
    tick();
    tests_run++;
    if (req_ready !== 4'b0010 || tim_cs !== 1'b1 || tim_wr !== 1'b1 || tim_rd !== 1'b0 || tim_addr !== TIM_ADDR_CTRL) begin
      failures++;
      $display("FAIL wr_t1: ready=%b cs=%b wr=%b rd=%b addr=%h, required 0010 1 1 0 1",
               req_ready, tim_cs, tim_wr, tim_rd, tim_addr);
    end
    req_valid = '0;
    tick();
    tests_run++;
    if (req_ready !== 4'b0000 || tim_cs !== 1'b1 || tim_wr !== 1'b1 || tim_addr !== TIM_ADDR_CTRL) begin
      failures++;
      $display("FAIL wr_t2: ready=%b cs=%b wr=%b addr=%h, required 0000 1 1 1", req_ready, tim_cs, tim_wr, tim_addr);
    end
    tick();
    tests_run++;
    if (tim_cs !== 1'b0 || tim_wr !== 1'b0 || rsp_valid !== 4'b0010 || rsp_data !== 16'h0000) begin
      failures++;
      $display("FAIL wr_t3: cs=%b wr=%b rsp=%b data=%h, required 0 0 0010 0000", tim_cs, tim_wr, rsp_valid, rsp_data);
    end
    tick();
  endtask

  task automatic test_single_read();
    apply_reset();
    use_fixed   = 1'b1;
    fixed_rdata = 16'h0123;
    req_valid   = 4'b0100;
    req_wr      = 4'b0000;
    req_addr    = 16'h0000;
    sb.push_back('{idx: 2, data: 16'h0123});
    for (int k = 1; k <= 3; k++) begin
      tick();
      if (k == 1) req_valid = '0;
      tests_run++;
      if (k < 3) begin
        if (tim_cs !== 1'b1 || tim_rd !== 1'b1 || tim_wr !== 1'b0 || tim_addr !== TIM_ADDR_COUNT) begin
          failures++;
          $display("FAIL rd_strobe t%0d: cs=%b rd=%b wr=%b addr=%h, required 1 1 0 0", k, tim_cs, tim_rd, tim_wr, tim_addr);
        end
      end else if (tim_rd !== 1'b0 || rsp_valid !== 4'b0100 || rsp_data !== 16'h0123) begin
        failures++;
        $display("FAIL rd_rsp: rd=%b rsp=%b data=%h, required 0 0100 0123", tim_rd, rsp_valid, rsp_data);
      end
    end
    tick();
    use_fixed = 1'b0;
  endtask

  task automatic test_round_robin();
    int cs_run;
    int unsigned who;
    apply_reset();
    req_valid = 4'b1111;
    req_wr    = 4'b0101;
    req_addr  = 16'h3210;
    sb.push_back('{idx: 0, data: 16'h0000});
    sb.push_back('{idx: 1, data: 16'hC0D1});
    sb.push_back('{idx: 2, data: 16'h0000});
    sb.push_back('{idx: 3, data: 16'hC0D3});
    sb.push_back('{idx: 0, data: 16'h0000});
    cs_run = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      who = 32'((k - 1) / 4) % NREQ;
      tests_run++;
      if (req_ready !== (((k - 1) % 4 == 0) ? oh(who) : 4'b0000)) begin
        failures++;
        $display("FAIL rr_ready c%0d: ready=%b, required %b", k, req_ready,
                 ((k - 1) % 4 == 0) ? oh(who) : 4'b0000);
      end
      tests_run++;
      if (tim_cs !== ((k - 1) % 4 < 2)) begin
        failures++;
        $display("FAIL rr_cs c%0d: cs=%b, required %b", k, tim_cs, ((k - 1) % 4 < 2));
      end
      cs_run = tim_cs ? cs_run + 1 : 0;
      tests_run++;
      if (cs_run > 2) begin
        failures++;
        $display("FAIL rr_cs_run c%0d: cs high %0d cycles, required at most 2", k, cs_run);
      end
    end
    req_valid = '0;
    repeat (3) tick();
  endtask

  task automatic test_withdraw();
    apply_reset();
    req_valid = 4'b1001;
    req_wr    = 4'b0000;
    req_addr  = 16'h3000;
    sb.push_back('{idx: 0, data: 16'hC0D0});
    sb.push_back('{idx: 0, data: 16'hC0D0});
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 2) req_valid[3] = 1'b0;
      if (k == 5) req_valid[0] = 1'b0;
      tests_run++;
      if (req_ready !== ((k == 1 || k == 5) ? 4'b0001 : 4'b0000)) begin
        failures++;
        $display("FAIL withdraw_ready c%0d: ready=%b, required %b", k, req_ready,
                 (k == 1 || k == 5) ? 4'b0001 : 4'b0000);
      end
    end
    repeat (2) tick();
  endtask

  task automatic test_reset_mid_access();
    apply_reset();
    req_valid = 4'b0010;
    req_wr    = 4'b0000;
    req_addr  = 16'h0020;
    tick();
    tests_run++;
    if (tim_cs !== 1'b1) begin
      failures++;
      $display("FAIL midrst_pre: cs=%b, required 1", tim_cs);
    end
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    tests_run++;
    if ({tim_cs, tim_rd, tim_wr} !== 3'b000 || req_ready !== '0) begin
      failures++;
      $display("FAIL midrst_drop: cs=%b rd=%b wr=%b ready=%b, required 0 0 0 0000", tim_cs, tim_rd, tim_wr, req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      tests_run++;
      if (rsp_valid !== '0 || tim_cs !== 1'b0) begin
        failures++;
        $display("FAIL midrst_norsp c%0d: rsp=%b cs=%b, required 0 0", k, rsp_valid, tim_cs);
      end
    end
  endtask

`ifdef TIMER_ARB_LOCK_EN
  task automatic test_lock();
    apply_reset();
    req_valid = 4'b0011;
    req_lock  = 4'b0001;
    req_wr    = 4'b0001;
    req_addr  = {8'h00, 4'h2, TIM_ADDR_CTRL};
    sb.push_back('{idx: 0, data: 16'h0000});
    sb.push_back('{idx: 0, data: 16'hC0D0});
    sb.push_back('{idx: 1, data: 16'hC0D2});
    for (int k = 1; k <= 12; k++) begin
      tick();
      tests_run++;
      if (req_ready !== ((k == 1 || k == 5) ? 4'b0001 : (k == 9) ? 4'b0010 : 4'b0000)) begin
        failures++;
        $display("FAIL lock_ready c%0d: ready=%b, required %b", k, req_ready,
                 (k == 1 || k == 5) ? 4'b0001 : (k == 9) ? 4'b0010 : 4'b0000);
      end
      if (k == 1) begin
        req_wr[0]     = 1'b0;
        req_addr[3:0] = TIM_ADDR_COUNT;
      end
      if (k == 5) begin
        tests_run++;
        if (tim_rd !== 1'b1 || tim_addr !== TIM_ADDR_COUNT) begin
          failures++;
          $display("FAIL lock_read: rd=%b addr=%h, required 1 0", tim_rd, tim_addr);
        end
        req_lock     = '0;
        req_valid[0] = 1'b0;
      end
      if (k == 9) req_valid[1] = 1'b0;
    end
    repeat (2) tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_round_robin();
    test_withdraw();
    test_reset_mid_access();
`ifdef TIMER_ARB_LOCK_EN
    test_lock();
`endif
    tests_run++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: %0d responses outstanding, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule

// File: doc/timer_access_arbiter.md
# timer_access_arbiter

Shares one `peripheral_timer` register port among `NREQ` on-chip requesters, such as a CPU bus bridge and a DMA/event engine. It arbitrates pending requests round-robin and sequences a single timer access per grant. Each access drives `cs`/`rd`/`wr`/`addr` for a fixed strobe window, captures the timer's 16-bit `data_out`, and returns it to the granted requester. The block sits directly between the requesters and the timer instance; nothing else drives the timer's bus.

## Interface
Parameters:
- `NREQ`, default 4: number of requesters, 2..8.
- `STROBE_CYCLES`, default 2: cycles `tim_cs` is held per access, minimum 1.

Ports:
- `clk`, in, 1: single clock.
- `rst`, in, 1: reset, asynchronous, active-low.
- `req_valid`, in, NREQ: request pending, one bit per requester.
- `req_wr`, in, NREQ: 1 = write access, 0 = read access.
- `req_addr`, in, 4*NREQ: timer register address; requester i uses bits [4i+3:4i].
- `req_ready`, out, NREQ: one-cycle grant pulse.
- `rsp_valid`, out, NREQ: one-cycle completion pulse.
- `rsp_data`, out, 16: captured read data, shared; valid only when a `rsp_valid` bit is high.
- `tim_cs`, out, 1: timer chip select.
- `tim_rd`, out, 1: timer read strobe.
- `tim_wr`, out, 1: timer write strobe.
- `tim_addr`, out, 4: timer register address.
- `tim_rdata`, in, 16: timer `data_out`.

## Operation
- FSM states:
  - IDLE: `tim_cs` low. If any `req_valid` bit is set, latch the winner index `g`, `req_addr[g]` and `req_wr[g]`, then go to ACCESS.
  - ACCESS: `tim_cs`=1; `tim_rd`=~wr_l; `tim_wr`=wr_l; `tim_addr`=addr_l. A strobe counter runs 0..STROBE_CYCLES-1. On its last cycle, load `rsp_data` with `tim_rdata` for a read, or with 16'h0000 for a write. Then go to RESP.
  - RESP: all timer strobes low; `rsp_valid[g]`=1. Advance the priority pointer to (g+1) mod NREQ, then go to IDLE.
- Round-robin rule: scan starts at the pointer and takes the first set `req_valid` bit, wrapping from NREQ-1 to 0. Pointer reset value is 0.
- Requester handshake:
  - The requester holds `req_valid`, `req_wr` and `req_addr` stable until it sees `req_ready`.
  - After `req_ready`, it may change or drop them; the address and direction were already latched.
  - If it re-asserts `req_valid` in the RESP cycle, that request competes at the next IDLE.
- Only one access is outstanding at a time. `tim_rd` and `tim_wr` are never both high.
- Dropping `req_valid` before `req_ready` withdraws the request; no access is issued for it.

## Timing
- Reset values:
  - FSM = IDLE.
  - `tim_cs`, `tim_rd`, `tim_wr` = 0; `tim_addr` = 0.
  - `req_ready`, `rsp_valid` = 0; `rsp_data` = 0; pointer = 0.
- All outputs are registered.
- Cycle sequence, with T0 = the IDLE cycle where `req_valid` is sampled:
  - T1 .. T(STROBE_CYCLES): ACCESS; `req_ready[g]` is high in T1 only.
  - T(STROBE_CYCLES+1): RESP; `rsp_valid[g]` is high.
  - T(STROBE_CYCLES+2): earliest next IDLE.
  - Next `tim_cs` assertion is at T(STROBE_CYCLES+3).
- Latency, request to response: STROBE_CYCLES+1 cycles. Throughput: one access per STROBE_CYCLES+2 cycles.
- `tim_cs` is low for at least 2 cycles between accesses (RESP + IDLE).
- Simultaneous requests are resolved solely by the pointer. Requests arriving during ACCESS/RESP wait.
- Asserting `rst` mid-ACCESS immediately drops all strobes and discards the transaction; no `rsp_valid` is generated.

## Configuration
- `TIMER_ARB_LOCK_EN` defined:
  - Adds input `req_lock` (NREQ bits).
  - If `req_lock[g]` is high in RESP, the pointer stays at g. The next IDLE grants only requester g (if `req_valid[g]`); other requesters are masked.
  - Lock releases when `req_lock[g]` is low in RESP, or when `req_valid[g]` is low in IDLE. Either way, the pointer then advances to g+1.
  - This allows atomic sequences such as "write control @1, then read count @0".
- `TIMER_ARB_LOCK_EN` undefined: the `req_lock` port is absent; plain round-robin applies.

## Structure
- Package `timer_arb_pkg`:
  - FSM state encoding: IDLE=2'd0, ACCESS=2'd1, RESP=2'd2.
  - Timer register address constants: TIM_ADDR_COUNT=4'h0, TIM_ADDR_CTRL=4'h1.
- Sub-module `rr_arbiter`: combinational rotate-priority arbiter. Inputs are request vector, pointer and mask; outputs are a one-hot grant and the winner index. The top level holds the FSM, latches and pointer.

## Test plan
- Reset held 5 cycles, released: all outputs 0, FSM IDLE. Assert `rst` low during ACCESS: strobes drop in the same cycle, no `rsp_valid`.
- Single write, NREQ=4, STROBE_CYCLES=2, requester 1 with addr 4'h1, wr=1: `tim_cs`=`tim_wr`=1 for 2 cycles with `tim_addr`=1; `rsp_valid[1]` at T3; `rsp_data`=0.
- Single read, requester 2 with addr 4'h0 while `tim_rdata`=16'h0123: `tim_rd` high 2 cycles; `rsp_valid[2]` with `rsp_data`=16'h0123.
- All four requesters held valid continuously: grant order 0,1,2,3,0 with accesses every 4 cycles; exactly one `req_ready` and one `rsp_valid` bit per access; `tim_cs` never high 3 cycles in a row.
- Requester 3 drops `req_valid` before its grant while 0 is being served: next grant goes to 0 again (pointer 1 → none pending → wrap); no access issued for requester 3.
- With `TIMER_ARB_LOCK_EN`: requester 0 locked, issues write@1 then read@0 while requester 1 is pending; both of requester 0's accesses complete back-to-back before requester 1 is granted.
